// File: rtl/key_line_controller.sv
// Keyboard line editor: collects released keys into a line buffer, expands tabs,
// handles backspace, and streams the line plus a CR terminator on enter.
module key_line_controller #(
   parameter int DEPTH     = 16,
   parameter int TAB_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   key_code,
   input  logic                         key_flag,
   input  logic                         key_enter,
   input  logic                         key_tab,
   input  logic                         key_bksp,
   output logic [7:0]                   out_char,
   output logic                         out_valid,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   len,
   output logic                         busy,
   output logic                         drop
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TAB_WIDTH + 1);
   localparam logic [LW-1:0] FULL  = LW'(DEPTH);
   localparam logic [CW-1:0] TAB_N = CW'(TAB_WIDTH);

   typedef enum logic [1:0] {EDIT, TAB, FLUSH} state_t;

   state_t          state;
   logic [LW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [7:0]      line_mem [DEPTH];

   // Bit order of the key vectors: {enter, bksp, tab, flag}.
   logic [3:0] raw, sync1, sync2, hist, ev;
   assign raw = {key_enter, key_bksp, key_tab, key_flag};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour; blocking here would
         // collapse the synchronizer chain into a single stage.
         sync1 <= raw;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign ev = sync2 & ~hist;

   logic ev_flag, ev_tab, ev_bksp, ev_enter;
   assign ev_flag  = ev[0];
   assign ev_tab   = ev[1];
   assign ev_bksp  = ev[2];
   assign ev_enter = ev[3];

   logic do_bksp, do_tab, do_flag, full;
   assign do_bksp = ev_bksp & ~ev_enter;
   assign do_tab  = ev_tab  & ~ev_enter & ~ev_bksp;
   assign do_flag = ev_flag & ~ev_enter & ~ev_bksp & ~ev_tab;
   assign full    = (len == FULL);

   logic       wr_en;
   logic [7:0] wr_data;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      wr_en   = 1'b0;
      wr_data = key_code;
      if (state == TAB) begin
         wr_en   = ~full;
         wr_data = 8'h20;
      end else if (state == EDIT) begin
         wr_en   = do_flag & ~full;
      end
   end

   // NOTE: the line buffer has no reset; its contents are unobservable while
   // len is 0, and leaving it out keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) line_mem[len[AW-1:0]] <= wr_data;
   end

   logic [LW-1:0] idx_next;
   logic [7:0]    rd_data;
   assign idx_next = idx + LW'(1);
   assign rd_data  = line_mem[idx_next[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EDIT;
         len       <= '0;
         idx       <= '0;
         cnt       <= '0;
         out_char  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         drop      <= 1'b0;
      end else begin
         drop <= 1'b0;
         case (state)
            EDIT: begin
               if (ev_enter) begin
                  state     <= FLUSH;
                  busy      <= 1'b1;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_char  <= (len == '0) ? 8'h0D : line_mem[0];
                  out_last  <= (len == '0);
               end else if (do_bksp) begin
                  if (len != '0) len <= len - LW'(1);
               end else if (do_tab) begin
                  state <= TAB;
                  busy  <= 1'b1;
                  cnt   <= TAB_N;
               end else if (do_flag) begin
                  if (full) drop <= 1'b1;
                  else      len  <= len + LW'(1);
               end
            end
            TAB: begin
               drop <= ev_flag;
               if (full) begin
                  // Tab on a full line: nothing fits, report it once and leave.
                  drop  <= 1'b1;
                  state <= EDIT;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  len <= len + LW'(1);
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1) || len == FULL - LW'(1)) begin
                     state <= EDIT;
                     busy  <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               drop <= ev_flag;
               if (out_ready) begin
                  if (out_last) begin
                     state     <= EDIT;
                     busy      <= 1'b0;
                     len       <= '0;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_char  <= 8'h00;
                     out_last  <= 1'b0;
                  end else begin
                     idx <= idx_next;
                     if (idx_next == len) begin
                        out_char <= 8'h0D;
                        out_last <= 1'b1;
                     end else begin
                        out_char <= rd_data;
                     end
                  end
               end
            end
            default: begin
               state <= EDIT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
